// File: rtl/hp_bar_pkg.sv
// Shared definitions for the HP bar and neighbouring sprite blocks.
// Holds the lag-tracker state enum, default bar geometry and game-state codes.
// Pure declarations, no logic.
package hp_bar_pkg;

  typedef enum logic [1:0] {
    LAG_IDLE  = 2'd0,
    LAG_HOLD  = 2'd1,
    LAG_DRAIN = 2'd2
  } lag_state_e;

  localparam int DEF_X0      = 0;
  localparam int DEF_Y0      = 400;
  localparam int DEF_HEIGHT  = 10;
  localparam int DEF_MAX_HP  = 100;
  localparam int DEF_COORD_W = 10;
  localparam int DEF_HP_W    = 10;
  localparam logic [15:0] DEF_ACTIVE_MASK = 16'h0006;

  // Game-state encodings shared with the other sprite blocks.
  localparam logic [3:0] GS_TITLE = 4'd0;
  localparam logic [3:0] GS_PLAY  = 4'd1;
  localparam logic [3:0] GS_PAUSE = 4'd2;
  localparam logic [3:0] GS_OVER  = 4'd3;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hp_lag_tracker.sv
// Frame-synchronous HP latch with delayed lag drain and damage-flash timer.
// Latency: all state changes one cycle after an accepted frame_tick.
// No backpressure: hp is sampled on every accepted tick, never stalls.
module hp_lag_tracker
  import hp_bar_pkg::*;
#(
  parameter int MAX_HP       = DEF_MAX_HP,
  parameter int HP_W         = DEF_HP_W,
  parameter int HOLD_FRAMES  = 30,
  parameter int DRAIN_STEP   = 1,
  parameter int FLASH_FRAMES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [HP_W-1:0] hp,
  input  logic            frame_tick,
  output logic [HP_W-1:0] hp_lat,
  output logic [HP_W-1:0] lag_hp,
  output logic            hit_flash
);

  localparam int HOLD_W  = cnt_width(HOLD_FRAMES);
  localparam int FLASH_W = cnt_width(FLASH_FRAMES);

  lag_state_e         state_q, state_d;
  logic [HP_W-1:0]    hp_lat_d, lag_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [FLASH_W-1:0] flash_q, flash_d;
  logic               armed_q;
  logic               tick;
  logic [HP_W-1:0]    h;
  logic [HP_W:0]      drain_floor;

  // A tick landing on the reset-release edge is dropped: armed_q is still 0 there.
  assign tick        = frame_tick & armed_q;
  assign h           = ({1'b0, hp} > (HP_W+1)'(MAX_HP)) ? HP_W'(MAX_HP) : hp;
  assign drain_floor = {1'b0, h} + (HP_W+1)'(DRAIN_STEP);
  assign hit_flash   = (flash_q != '0);

  // State register plus latched HP, lag value and frame counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LAG_IDLE;
      hp_lat  <= '0;
      lag_hp  <= '0;
      hold_q  <= '0;
      flash_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_lat  <= hp_lat_d;
      lag_hp  <= lag_d;
      hold_q  <= hold_d;
      flash_q <= flash_d;
      armed_q <= 1'b1;
    end
  end

  // Next-state: damage restarts hold/flash, a heal to or above lag snaps, otherwise hold then drain.
  always_comb begin
    state_d  = state_q;
    hp_lat_d = hp_lat;
    lag_d    = lag_hp;
    hold_d   = hold_q;
    flash_d  = flash_q;
    if (tick) begin
      hp_lat_d = h;
      if (flash_q != '0) flash_d = flash_q - 1'b1;
      if (h < hp_lat) begin
        state_d = LAG_HOLD;
        hold_d  = HOLD_W'(HOLD_FRAMES);
        flash_d = FLASH_W'(FLASH_FRAMES);
      end else if (h >= lag_hp) begin
        state_d = LAG_IDLE;
        lag_d   = h;
      end else begin
        unique case (state_q)
          LAG_HOLD: begin
            if (hold_q <= HOLD_W'(1)) begin
              hold_d  = '0;
              state_d = LAG_DRAIN;
            end else begin
              hold_d = hold_q - 1'b1;
            end
          end
          LAG_DRAIN: begin
            // Drain toward the freshly latched HP without stepping below it.
            if ({1'b0, lag_hp} > drain_floor) begin
              lag_d = lag_hp - HP_W'(DRAIN_STEP);
            end else begin
              lag_d   = h;
              state_d = LAG_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/hp_bar_renderer.sv
// HP bar pixel classifier: live HP, trailing lag and empty background segments.
// Latency: pixel outputs registered, 1 cycle from x/y/state; hp visible after next frame_tick.
// No backpressure: a new scan position is accepted every cycle.
module hp_bar_renderer
  import hp_bar_pkg::*;
#(
  parameter int          X0           = DEF_X0,
  parameter int          Y0           = DEF_Y0,
  parameter int          HEIGHT       = DEF_HEIGHT,
  parameter int          MAX_HP       = DEF_MAX_HP,
  parameter int          COORD_W      = DEF_COORD_W,
  parameter int          HP_W         = DEF_HP_W,
  parameter logic [15:0] ACTIVE_MASK  = DEF_ACTIVE_MASK,
  parameter int          HOLD_FRAMES  = 30,
  parameter int          DRAIN_STEP   = 1,
  parameter int          FLASH_FRAMES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         state,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [HP_W-1:0]    hp,
  input  logic               frame_tick,
  output logic               bar_fg_on,
  output logic               bar_lag_on,
  output logic               bar_bg_on,
  output logic               hit_flash
);

  // One extra bit over the widest operand so X0+MAX_HP and Y0+HEIGHT never wrap.
  localparam int CMP_W = ((COORD_W > HP_W) ? COORD_W : HP_W) + 1;

  logic [HP_W-1:0]  hp_lat, lag_hp;
  logic [CMP_W-1:0] x_e, y_e, c, lat_e, lag_e;
  logic             in_rows, in_cols, hit;
  logic             fg_d, lag_d, bg_d;

  hp_lag_tracker #(
    .MAX_HP      (MAX_HP),
    .HP_W        (HP_W),
    .HOLD_FRAMES (HOLD_FRAMES),
    .DRAIN_STEP  (DRAIN_STEP),
    .FLASH_FRAMES(FLASH_FRAMES)
  ) u_trk (
    .clk       (clk),
    .rst_n     (rst_n),
    .hp        (hp),
    .frame_tick(frame_tick),
    .hp_lat    (hp_lat),
    .lag_hp    (lag_hp),
    .hit_flash (hit_flash)
  );

  assign x_e     = CMP_W'(x);
  assign y_e     = CMP_W'(y);
  assign lat_e   = CMP_W'(hp_lat);
  assign lag_e   = CMP_W'(lag_hp);
  assign in_cols = (x_e >= CMP_W'(X0));
  assign c       = x_e - CMP_W'(X0);
  assign in_rows = (y_e > CMP_W'(Y0)) && (y_e <= CMP_W'(Y0 + HEIGHT));
  assign hit     = ACTIVE_MASK[state] && in_rows && in_cols;

  // Segments are disjoint because hp_lat <= lag_hp <= MAX_HP always holds.
  assign fg_d  = hit && (c < lat_e);
  assign lag_d = hit && (c >= lat_e) && (c < lag_e);
  assign bg_d  = hit && (c >= lag_e) && (c < CMP_W'(MAX_HP));

  // Output registers; an inactive game state clears them on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_fg_on  <= 1'b0;
      bar_lag_on <= 1'b0;
      bar_bg_on  <= 1'b0;
    end else begin
      bar_fg_on  <= fg_d;
      bar_lag_on <= lag_d;
      bar_bg_on  <= bg_d;
    end
  end

endmodule

// File: doc/hp_bar_renderer.md
# hp_bar_renderer

Parametrised successor to the single-rectangle HP indicator. Renders a horizontal HP bar with three pixel classes: live HP, trailing damage lag, and empty background up to max HP. Adds frame-synchronous HP sampling, a delayed drain animation, and a damage flash. Sits between game-state logic and the pixel colour mux, fed by the VGA scan counters.

## Interface
- `X0`, default 0: left edge column of the bar.
- `Y0`, default 400: bar occupies rows `Y0 < y <= Y0+HEIGHT`.
- `HEIGHT`, default 10: bar height in rows.
- `MAX_HP`, default 100: full-bar width in pixels (1 px per HP point).
- `COORD_W`, default 10: width of `x`, `y`.
- `HP_W`, default 10: width of `hp`.
- `ACTIVE_MASK`, default 16'h0006: bit `s` set means game state `s` draws the bar (default: states 1, 2).
- `HOLD_FRAMES`, default 30: frames the lag segment holds before draining.
- `DRAIN_STEP`, default 1: HP points drained per frame.
- `FLASH_FRAMES`, default 8: damage-flash duration in frames.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `state` in 4: game state.
- `x`, `y` in COORD_W: current scan position.
- `hp` in HP_W: current player HP, may change at any time.
- `frame_tick` in 1: one-cycle pulse per frame, at vsync start.
- `bar_fg_on` out 1: pixel is live HP.
- `bar_lag_on` out 1: pixel is recently lost HP.
- `bar_bg_on` out 1: pixel is empty bar area.
- `hit_flash` out 1: high while the damage flash is active, frame-stable.

## Operation
- `hp_lat`: `hp` clamped to MAX_HP, captured only on `frame_tick`. No mid-frame tearing.
- `lag_hp`: displayed trailing value, always `>= hp_lat`.
- FSM, updated only on `frame_tick`, using the newly captured value `h`:
  - **IDLE**: `lag_hp == hp_lat`.
    - If `h < hp_lat`: go to HOLD, hold counter = HOLD_FRAMES, flash counter = FLASH_FRAMES.
    - If `h >= hp_lat`: `lag_hp <= h` (heals snap).
  - **HOLD**: decrement the hold counter; at 0 go to DRAIN.
  - **DRAIN**: `lag_hp <= max(lag_hp - DRAIN_STEP, hp_lat)`; on reaching `hp_lat` go to IDLE.
  - **Any state**: further damage (`h < hp_lat`) restarts HOLD and the flash, and keeps `lag_hp`.
  - **Any state**: a heal with `h >= lag_hp` snaps `lag_hp <= h` and goes to IDLE.
- The flash counter decrements per `frame_tick` while nonzero. `hit_flash = (flash_cnt != 0)`.
- Pixel classification, with `c = x - X0` valid only when `x >= X0`, and `in_rows = (y > Y0) && (y <= Y0+HEIGHT)`:
  - fg: `in_rows && c < hp_lat`
  - lag: `in_rows && hp_lat <= c < lag_hp`
  - bg: `in_rows && lag_hp <= c < MAX_HP`
  - At most one of the three is high.
- Inactive state (`ACTIVE_MASK[state] == 0`): all three pixel outputs are 0. Counters and FSM keep running. Pixel outputs are explicitly cleared, never held.
- Comparisons use `COORD_W+1` bits so that `X0+MAX_HP` and `Y0+HEIGHT` never wrap.

## Timing
- Pixel outputs are registered, with latency 1 cycle from `x`/`y`/`state`.
- `hp` to `hp_lat`: visible from the first pixel after the next `frame_tick`.
- Reset values: all outputs 0, FSM IDLE, `hp_lat = 0`, `lag_hp = 0`, counters 0.
- The first `frame_tick` after reset captures `hp` as a heal, so there is no flash at power-up.
- A `frame_tick` coinciding with reset release is ignored.
- `hp` changing on a non-tick cycle has no effect until the next tick.

## Structure
- Shared package `hp_bar_pkg`:
  - FSM state enum (IDLE, HOLD, DRAIN).
  - Default geometry constants.
  - Game-state encodings reused by other sprite blocks.
- One natural sub-module, `hp_lag_tracker`: owns the FSM, `hp_lat`, `lag_hp` and the counters, with outputs `hp_lat`, `lag_hp`, `hit_flash`. The top level does the pixel compare and the output registers.

## Test plan
1. **Reset, then heal-capture.** Hold `rst_n=0`, then release with `hp=80` and one `frame_tick`.
   - Required: `hit_flash=0`, row 405 shows fg for `x=0..79`, bg for `x=80..99`, nothing at `x=100`.
2. **Damage, hold, drain.** Apply `hp` 80→60 with `frame_tick`.
   - Lag for `x=60..79` for 30 frames, then lag shrinks 1 px per frame.
   - After frame 50, lag is empty and the FSM is back in IDLE.
   - `hit_flash` is high for exactly 8 frames.
3. **Re-hit during DRAIN.** At `lag_hp=70`, apply `hp` 60→40.
   - Required: HOLD restarts, lag covers `x=40..69`, flash retriggers.
4. **Heal above lag.** Mid-HOLD with `lag_hp=80`, apply `hp=90`.
   - Required: fg `x=0..89`, no lag, FSM back in IDLE.
5. **Inactive state and boundaries.**
   - `state=0` forces all outputs to 0 while the FSM keeps draining.
   - Rows 400 and 411 are off; rows 401 and 410 are on.
   - `hp=150` clamps the bar at 100 px.
6. **Mid-frame change.** Apply `hp` 80→20 with no `frame_tick`.
   - Required: the bar stays at 80 for the rest of the frame and updates only after the next tick.
